// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MUL_DIV_EARLY_OUT_EN lets trivial operations bypass the iteration phase.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       operator,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_is_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpRem    = 3'd6;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               neg_q, neg_d;
    logic               zero_q, zero_d;

    logic               accept;
    logic               a_signed, b_signed, sa, sb, div_zero;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   div_sel, div_fix, fix_result;

    assign accept   = in_valid && (state_q == StIdle) && !flush;
    assign a_signed = operator inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    assign b_signed = operator inside {OpMul, OpMulh, OpDiv, OpRem};
    assign sa       = a_signed && operand1[WIDTH-1];
    assign sb       = b_signed && operand2[WIDTH-1];
    assign a_abs    = sa ? -operand1 : operand1;
    assign b_abs    = sb ? -operand2 : operand2;
    assign div_zero = (operand2 == '0);

`ifdef MUL_DIV_EARLY_OUT_EN
    logic             early;
    logic             div_ovf;
    logic [WIDTH-1:0] early_acc, early_lo;

    assign div_ovf   = (operator inside {OpDiv, OpRem}) &&
                       (operand1 == {1'b1, {(WIDTH-1){1'b0}}}) && (operand2 == '1);
    assign early     = operator[2] ? (div_zero || div_ovf)
                                   : (div_zero || (operand2 == WIDTH'(1)));
    // Preload the magnitudes the iteration would have produced.
    assign early_acc = (operator[2] && div_zero) ? a_abs : '0;
    assign early_lo  = operator[2] ? (div_zero ? '1 : a_abs) : (div_zero ? '0 : a_abs);
`endif

    // Multiply: {acc, lo} shifts right, multiplier consumed from lo[0].
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Divide: {acc, lo} shifts left, quotient bits enter at lo[0].
    assign div_shift = {acc_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};

    assign prod     = {acc_q, lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign div_sel  = op_q[1] ? acc_q : lo_q;
    assign div_fix  = neg_q ? -div_sel : div_sel;

    always_comb begin
        fix_result = '0;
        if (op_q[2]) begin
            fix_result = div_fix;
        end else if (op_q == OpMul) begin
            fix_result = prod_fix[WIDTH-1:0];
        end else begin
            fix_result = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        b_d      = b_q;
        neg_d    = neg_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCalc;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    op_d    = operator;
                    acc_d   = '0;
                    lo_d    = operator[2] ? a_abs : b_abs;
                    b_d     = operator[2] ? b_abs : a_abs;
                    // Quotient of a divide-by-zero is -1 regardless of operand signs.
                    neg_d   = operator[2] ? (operator[1] ? sa : ((sa ^ sb) && !div_zero))
                                          : (sa ^ sb);
`ifdef MUL_DIV_EARLY_OUT_EN
                    if (early) begin
                        state_d = StFix;
                        cnt_d   = '0;
                        acc_d   = early_acc;
                        lo_d    = early_lo;
                    end
`endif
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    if (op_q[2]) begin
                        if (!div_diff[WIDTH]) begin
                            acc_d = div_diff[WIDTH-1:0];
                            lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = div_shift[WIDTH-1:0];
                            lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StFix: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    result_d = fix_result;
                    zero_d   = (fix_result == '0);
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (flush || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready       = (state_q == StIdle);
    assign out_valid      = (state_q == StDone);
    assign busy           = (state_q != StIdle);
    assign result         = result_q;
    assign result_is_zero = zero_q;

endmodule
